// File: rtl/freelist_pkg.sv
// Shared rename/dispatch constants: physical register file, free list and ROB sizing.
// Also holds the derived pointer and counter widths used by the free list.
package freelist_pkg;

  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS            = 64;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int ARCH_REGS            = 32;
  localparam int FREELIST_DEPTH       = PHYS_REGS - ARCH_REGS;

  localparam int ROB_DEPTH            = 32;
  localparam int ROB_PTR_W            = $clog2(ROB_DEPTH);

  localparam int FL_PTR_W             = $clog2(FREELIST_DEPTH);
  localparam int FL_CNT_W             = $clog2(FREELIST_DEPTH) + 1;
  localparam int LANE_CNT_W           = $clog2(DISPATCH_WIDTH + 1);

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount over a lane mask: offset[i] = number of set lanes below i.
// Used to compact sparse lane requests onto consecutive queue slots.
module lane_prefix_count #(
  parameter int LANES = 2,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]       mask,
  output logic [LANES*CNT_W-1:0] offset,
  output logic [CNT_W-1:0]       total
);

  logic [CNT_W-1:0] run;

  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i*CNT_W +: CNT_W] = run;
      run = run + CNT_W'(mask[i]);
    end
    total = run;
  end

endmodule

// File: rtl/freelist.sv
// Circular free list of physical register tags: all-or-nothing multi-lane allocation
// from head, compacted multi-lane release at tail, sticky overflow on excess release.
module freelist
  import freelist_pkg::*;
(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [DISPATCH_WIDTH-1:0]                      alloc_req,
  output logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] alloc_phys_rd,
  output logic                                           alloc_ok,
  input  logic [DISPATCH_WIDTH-1:0]                      release_en,
  input  logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] release_phys_rd,
  output logic [FL_CNT_W-1:0]                            free_count,
  output logic                                           overflow_err
);

  localparam int AW = PHYS_REGS_ADDR_WIDTH;

  logic [AW-1:0]                        entry [FREELIST_DEPTH];
  logic [FL_PTR_W-1:0]                  head;
  logic [FL_PTR_W-1:0]                  tail;
  logic [FL_CNT_W-1:0]                  count;

  logic [DISPATCH_WIDTH*LANE_CNT_W-1:0] alloc_off;
  logic [DISPATCH_WIDTH*LANE_CNT_W-1:0] rel_off;
  logic [LANE_CNT_W-1:0]                n_req;
  logic [LANE_CNT_W-1:0]                n_rel;
  logic [FL_CNT_W-1:0]                  n_grant;
  logic [FL_CNT_W-1:0]                  count_after_alloc;
  logic [FL_CNT_W-1:0]                  room;
  logic [FL_CNT_W-1:0]                  n_rel_ext;
  logic [FL_CNT_W-1:0]                  n_write;
  logic [DISPATCH_WIDTH-1:0]            rel_keep;
  logic                                 overflow_now;

  lane_prefix_count #(
    .LANES (DISPATCH_WIDTH),
    .CNT_W (LANE_CNT_W)
  ) u_alloc_prefix (
    .mask   (alloc_req),
    .offset (alloc_off),
    .total  (n_req)
  );

  lane_prefix_count #(
    .LANES (DISPATCH_WIDTH),
    .CNT_W (LANE_CNT_W)
  ) u_rel_prefix (
    .mask   (release_en),
    .offset (rel_off),
    .total  (n_rel)
  );

  // Grant decision uses only the registered count; same-cycle releases are not visible.
  assign alloc_ok = (FL_CNT_W'(n_req) <= count);

  always_comb begin
    alloc_phys_rd = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (alloc_req[i]) begin
        alloc_phys_rd[i*AW +: AW] =
          entry[head + FL_PTR_W'(alloc_off[i*LANE_CNT_W +: LANE_CNT_W])];
      end
    end
  end

  assign n_grant           = alloc_ok ? FL_CNT_W'(n_req) : '0;
  assign count_after_alloc = count - n_grant;
  assign room              = FL_CNT_W'(FREELIST_DEPTH) - count_after_alloc;
  assign n_rel_ext         = FL_CNT_W'(n_rel);
  assign overflow_now      = (n_rel_ext > room);
  assign n_write           = overflow_now ? room : n_rel_ext;

  // Lower lanes win the remaining room; releases beyond it are dropped.
  always_comb begin
    rel_keep = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rel_keep[i] = release_en[i] &&
                    (FL_CNT_W'(rel_off[i*LANE_CNT_W +: LANE_CNT_W]) < room);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FREELIST_DEPTH; k++) begin
        entry[k] <= AW'(ARCH_REGS + k);
      end
      head         <= '0;
      tail         <= '0;
      count        <= FL_CNT_W'(FREELIST_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (rel_keep[i]) begin
          entry[tail + FL_PTR_W'(rel_off[i*LANE_CNT_W +: LANE_CNT_W])] <=
            release_phys_rd[i*AW +: AW];
        end
      end
      head  <= head + n_grant[FL_PTR_W-1:0];
      tail  <= tail + n_write[FL_PTR_W-1:0];
      count <= count_after_alloc + n_write;
      if (overflow_now) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign free_count = count;

endmodule

// File: doc/freelist.md
# freelist

Circular free list of physical register tags for the rename stage, directly upstream of the ROB dispatch port. Each cycle it hands up to DISPATCH_WIDTH free physical destination tags to rename; those tags travel on into the ROB as the dispatch physical destination. It also takes back up to DISPATCH_WIDTH tags per cycle from the commit path. Allocation is all-or-nothing per cycle, so rename never sees a partially renamed dispatch group.

## Interface
- DISPATCH_WIDTH, 2, lanes per cycle, shared with the ROB.
- PHYS_REGS, 64, number of physical registers.
- PHYS_REGS_ADDR_WIDTH, 6, equals clog2(PHYS_REGS).
- FREELIST_DEPTH, PHYS_REGS-32, number of entries; must be a power of two.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_req  in  1 x DISPATCH_WIDTH  lane i requests a tag.
- alloc_phys_rd  out  PHYS_REGS_ADDR_WIDTH x DISPATCH_WIDTH  tag for lane i.
- alloc_ok  out  1  the whole request group is granted this cycle.
- release_en  in  1 x DISPATCH_WIDTH  lane i returns a tag.
- release_phys_rd  in  PHYS_REGS_ADDR_WIDTH x DISPATCH_WIDTH  tag returned by lane i.
- free_count  out  clog2(FREELIST_DEPTH)+1  number of free entries (registered).
- overflow_err  out  1  sticky flag: a release was attempted while the list was full.

## Operation
- Storage: FREELIST_DEPTH-entry array, head pointer (read), tail pointer (write), count.
  - Both pointers are clog2(FREELIST_DEPTH) bits and wrap modulo FREELIST_DEPTH.
- Reset state:
  - entry[k] = 32+k; head = 0; tail = 0; count = FREELIST_DEPTH; overflow_err = 0.
  - Physical registers 0..31 belong to the initial architectural mapping and are never in the list at reset.
- Allocation:
  - n_req = popcount(alloc_req).
  - alloc_ok = (n_req <= count) and combinational.
  - Requesting lanes receive entry[head], entry[head+1], … in ascending lane order.
  - Lanes that do not request get no entry, and their slot is not consumed. Example: req = 2'b10 → lane1 gets entry[head].
  - When alloc_ok is 1, head advances by n_req.
  - When alloc_ok is 0, nothing is consumed, and alloc_phys_rd is don't-care.
  - alloc_ok is 1 when n_req = 0.
- Release:
  - Enabled lanes write entry[tail], entry[tail+1], … in ascending lane order; tail advances by popcount(release_en).
  - Gaps between enabled lanes are compacted.
- Count update: count_next = count − (alloc_ok ? n_req : 0) + n_rel.
- Simultaneous alloc and release:
  - Both are legal in the same cycle.
  - Tags released in cycle t are allocatable from cycle t+1, never in the same cycle; alloc_ok uses the registered count only.
- Overflow:
  - If count + n_rel exceeds FREELIST_DEPTH (after subtracting the cycle's allocation), overflow_err is set and held until reset.
  - The excess releases are dropped; tail and count saturate at the capacity limit.
- Tag values are not checked; releasing tag 0 is the caller's responsibility.

## Timing
- Allocation output is combinational from the registered head and array: 0-cycle latency, no storage added on the rename path.
- Release takes effect at the next rising edge.
- free_count reflects the state after the previous edge.
- Reset is asynchronous assert and synchronous deassert (deasserted externally).
  - A reset mid-operation reloads the reset state immediately.
  - Any in-flight requests are discarded.
- Wrap-around: a group straddling index FREELIST_DEPTH−1→0 must return entry[DEPTH−1] then entry[0], with no bubble.

## Structure
- DISPATCH_WIDTH, PHYS_REGS, PHYS_REGS_ADDR_WIDTH and FREELIST_DEPTH live in the shared parameters package, next to the ROB constants.
- Lane compaction (prefix popcount → per-lane offset) is a small generic sub-module, lane_prefix_count.
  - It is instantiated twice, once for allocation and once for release.
  - The ROB dispatch path can reuse it.
- Everything else is flat in freelist.

## Test plan
- Reset, then alloc_req = 11 → alloc_phys_rd = {32,33}, alloc_ok = 1; next cycle free_count = 30 and outputs = {34,35}.
- 16 cycles of req = 11 → free_count = 0; then req = 01 → alloc_ok = 0; head and count unchanged.
- With free_count = 1:
  - req = 11 → alloc_ok = 0 (all-or-nothing).
  - req = 10 → lane1 = the last tag, alloc_ok = 1.
- With free_count = 0: release lanes 10 with tag 40 and req = 11 in the same cycle → alloc_ok = 0. Next cycle free_count = 1, and req = 01 → lane0 = 40.
- Drive head to 31 with release_en = 11 continuously → the group returns entry[31], entry[0] in order; pointers wrap; count stays consistent.
- Release while count = 32 → overflow_err = 1 and count stays 32. Pulse rst low mid-cycle → immediately count = 32, alloc_phys_rd = {32,33}, overflow_err = 0.
